// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OPS_W  = 4;

    // Opcodes understood by the shared ALU; anything above OP_LAST is illegal.
    localparam logic [OPS_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPS_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPS_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPS_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPS_W-1:0] OP_OR   = 4'd4;
    localparam logic [OPS_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OPS_W-1:0] OP_NOT  = 4'd6;
    localparam logic [OPS_W-1:0] OP_SHL  = 4'd7;
    localparam logic [OPS_W-1:0] OP_SHR  = 4'd8;
    localparam logic [OPS_W-1:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic op_illegal(input logic [OPS_W-1:0] s);
        return s > OP_LAST;
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU shared by the arbiter's requesters.
module alu8
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OPS_W-1:0]  s,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    // Opcode decode; ADD/SUB wrap naturally at 8 bits, illegal codes give 0.
    always_comb begin
        result = '0;
        err    = op_illegal(s);
        case (s)
            OP_NOP: result = '0;
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: result = {a[DATA_W-2:0], 1'b0};
            OP_SHR: result = {1'b0, a[DATA_W-1:1]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant: round-robin on contention when FAIR!=0, else port 0 first.
module rr_arb2 #(
    parameter int FAIR = 1
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // On a tie, port 1 wins only in fair mode when port 0 was granted last.
    logic tie_to1;

    assign tie_to1 = (FAIR != 0) && !last_grant;

    // One-hot grant; zero when nobody is asking.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = valid[0] & ~(valid[1] & tie_to1);
        gnt[1] = valid[1] & (~valid[0] | tie_to1);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; one operation in flight at a time.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int FAIR  = 1,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_opA,
    input  logic [DATA_W-1:0]   req0_opB,
    input  logic [OPS_W-1:0]    req0_opS,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_opA,
    input  logic [DATA_W-1:0]   req1_opB,
    input  logic [OPS_W-1:0]    req1_opS,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [DATA_W-1:0]   rsp0_result,
    output logic                rsp0_err,
    output logic                rsp0_zero,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [DATA_W-1:0]   rsp1_result,
    output logic                rsp1_err,
    output logic                rsp1_zero,
    output logic                busy,
    output logic [CNT_W-1:0]    done_count
);

    logic [1:0]                req_vld;
    logic [1:0]                gnt;
    logic [1:0][DATA_W-1:0]    req_a;
    logic [1:0][DATA_W-1:0]    req_b;
    logic [1:0][OPS_W-1:0]     req_s;

    state_t                    state;
    logic                      owner;
    logic                      last_grant;
    logic [DATA_W-1:0]         op_a;
    logic [DATA_W-1:0]         op_b;
    logic [OPS_W-1:0]          op_s;
    logic [DATA_W-1:0]         res_q;
    logic                      err_q;
    logic                      zero_q;
    logic [1:0]                rsp_vld;
    logic [1:0]                rsp_rdy;
    logic                      rsp_hs;

    logic [DATA_W-1:0]         alu_res;
    logic                      alu_err;

    logic [1:0][DATA_W-1:0]    rsp_res;
    logic [1:0]                rsp_e;
    logic [1:0]                rsp_z;

    assign req_vld = {req1_valid, req0_valid};
    assign req_a   = {req1_opA, req0_opA};
    assign req_b   = {req1_opB, req0_opB};
    assign req_s   = {req1_opS, req0_opS};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};
    assign rsp_hs  = |(rsp_vld & rsp_rdy);

    rr_arb2 #(.FAIR(FAIR)) u_arb (
        .valid      (req_vld),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    alu8 u_alu (
        .a      (op_a),
        .b      (op_b),
        .s      (op_s),
        .result (alu_res),
        .err    (alu_err)
    );

    // Accept is only possible from IDLE, so ready is the grant gated by state.
    assign req0_ready = (state == IDLE) & gnt[0];
    assign req1_ready = (state == IDLE) & gnt[1];
    assign busy       = (state != IDLE);

    // Control FSM: latch the granted request, run the ALU for a cycle, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_s       <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            zero_q     <= 1'b0;
            rsp_vld    <= 2'b00;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        owner      <= gnt[1];
                        last_grant <= gnt[1];
                        op_a       <= req_a[gnt[1]];
                        op_b       <= req_b[gnt[1]];
                        op_s       <= req_s[gnt[1]];
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= alu_res;
                    err_q   <= alu_err;
                    zero_q  <= (alu_res == '0);
                    rsp_vld <= owner ? 2'b10 : 2'b01;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_vld    <= 2'b00;
                        done_count <= done_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the owning port sees the captured result; the other reads zero.
    for (genvar p = 0; p < 2; p++) begin : g_rsp
        assign rsp_res[p] = rsp_vld[p] ? res_q : '0;
        assign rsp_e[p]   = rsp_vld[p] & err_q;
        assign rsp_z[p]   = rsp_vld[p] & zero_q;
    end

    assign rsp0_valid  = rsp_vld[0];
    assign rsp1_valid  = rsp_vld[1];
    assign rsp0_result = rsp_res[0];
    assign rsp1_result = rsp_res[1];
    assign rsp0_err    = rsp_e[0];
    assign rsp1_err    = rsp_e[1];
    assign rsp0_zero   = rsp_z[0];
    assign rsp1_zero   = rsp_z[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: instance 0 is fair/16-bit count, instance 1 fixed/2-bit count.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [2];
    logic       req_valid  [2][2];
    logic [7:0] req_a      [2][2];
    logic [7:0] req_b      [2][2];
    logic [3:0] req_s      [2][2];
    logic       req_ready  [2][2];
    logic       rsp_valid  [2][2];
    logic       rsp_ready  [2][2];
    logic [7:0] rsp_result [2][2];
    logic       rsp_err    [2][2];
    logic       rsp_zero   [2][2];
    logic       busy       [2];
    logic [15:0] dc0;
    logic [1:0]  dc1;

    typedef struct packed { logic [7:0] a; logic [7:0] b; logic [3:0] s; } op_t;
    typedef struct packed { logic [7:0] res; logic err; logic zero; } exp_t;

    op_t  pend [4][$];
    exp_t sb   [4][$];
    int   glog [2][$];
    int   nvec = 0;
    int   errs = 0;

    alu_arbiter #(.FAIR(1), .CNT_W(16)) u_fair (
        .clk(clk), .rst(rst[0]),
        .req0_valid(req_valid[0][0]), .req0_ready(req_ready[0][0]),
        .req0_opA(req_a[0][0]), .req0_opB(req_b[0][0]), .req0_opS(req_s[0][0]),
        .req1_valid(req_valid[0][1]), .req1_ready(req_ready[0][1]),
        .req1_opA(req_a[0][1]), .req1_opB(req_b[0][1]), .req1_opS(req_s[0][1]),
        .rsp0_valid(rsp_valid[0][0]), .rsp0_ready(rsp_ready[0][0]),
        .rsp0_result(rsp_result[0][0]), .rsp0_err(rsp_err[0][0]), .rsp0_zero(rsp_zero[0][0]),
        .rsp1_valid(rsp_valid[0][1]), .rsp1_ready(rsp_ready[0][1]),
        .rsp1_result(rsp_result[0][1]), .rsp1_err(rsp_err[0][1]), .rsp1_zero(rsp_zero[0][1]),
        .busy(busy[0]), .done_count(dc0)
    );

    alu_arbiter #(.FAIR(0), .CNT_W(2)) u_fixed (
        .clk(clk), .rst(rst[1]),
        .req0_valid(req_valid[1][0]), .req0_ready(req_ready[1][0]),
        .req0_opA(req_a[1][0]), .req0_opB(req_b[1][0]), .req0_opS(req_s[1][0]),
        .req1_valid(req_valid[1][1]), .req1_ready(req_ready[1][1]),
        .req1_opA(req_a[1][1]), .req1_opB(req_b[1][1]), .req1_opS(req_s[1][1]),
        .rsp0_valid(rsp_valid[1][0]), .rsp0_ready(rsp_ready[1][0]),
        .rsp0_result(rsp_result[1][0]), .rsp0_err(rsp_err[1][0]), .rsp0_zero(rsp_zero[1][0]),
        .rsp1_valid(rsp_valid[1][1]), .rsp1_ready(rsp_ready[1][1]),
        .rsp1_result(rsp_result[1][1]), .rsp1_err(rsp_err[1][1]), .rsp1_zero(rsp_zero[1][1]),
        .busy(busy[1]), .done_count(dc1)
    );

    // Reference ALU written from the opcode table.
    function automatic exp_t model(input op_t o);
        exp_t e;
        e.err = 1'b0;
        case (o.s)
            4'd0: e.res = 8'h00;
            4'd1: e.res = o.a + o.b;
            4'd2: e.res = o.a - o.b;
            4'd3: e.res = o.a & o.b;
            4'd4: e.res = o.a | o.b;
            4'd5: e.res = o.a ^ o.b;
            4'd6: e.res = ~o.a;
            4'd7: e.res = o.a << 1;
            4'd8: e.res = o.a >> 1;
            default: begin e.res = 8'h00; e.err = 1'b1; end
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present the next queued op on any idle requester.
    task automatic refill();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (!req_valid[d][p] && pend[d*2+p].size() > 0) begin
                    op_t o;
                    o = pend[d*2+p].pop_front();
                    req_a[d][p] = o.a;
                    req_b[d][p] = o.b;
                    req_s[d][p] = o.s;
                    req_valid[d][p] = 1'b1;
                end
    endtask

    task automatic push_op(input int d, input int p, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] s);
        op_t o;
        o = '{a: a, b: b, s: s};
        pend[d*2+p].push_back(o);
        sb[d*2+p].push_back(model(o));
        refill();
    endtask

    // One clock: observe handshakes before the edge, then update requesters after it.
    task automatic step();
        bit acc [2][2];
        exp_t e;
        #2;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                acc[d][p] = req_valid[d][p] && req_ready[d][p];
                if (rsp_valid[d][p] && rsp_ready[d][p]) begin
                    if (sb[d*2+p].size() == 0)
                        chk($sformatf("rsp_unexpected_d%0d_p%0d", d, p), 32'(rsp_valid[d][p]), 0);
                    else begin
                        e = sb[d*2+p].pop_front();
                        chk($sformatf("rsp_d%0d_p%0d", d, p),
                            32'({rsp_result[d][p], rsp_err[d][p], rsp_zero[d][p]}), 32'(e));
                    end
                end else if (!rsp_valid[d][p]) begin
                    chk($sformatf("rsp_quiet_d%0d_p%0d", d, p),
                        32'({rsp_result[d][p], rsp_err[d][p], rsp_zero[d][p]}), 0);
                end
            end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (acc[d][p]) begin
                    req_valid[d][p] = 1'b0;
                    glog[d].push_back(p);
                end
        refill();
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        while ((sb[d*2].size() > 0 || sb[d*2+1].size() > 0 || busy[d]) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk($sformatf("wait_idle_timeout_d%0d", d), n, 0);
    endtask

    // Asynchronous reset pulse mid-cycle, checking outputs while it is held.
    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req_valid[d][p] = 1'b0;
            pend[d*2+p].delete();
            sb[d*2+p].delete();
        end
        glog[d].delete();
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_ready_d%0d_p%0d", d, p), 32'(req_ready[d][p]), 0);
            chk($sformatf("rst_rsp_d%0d_p%0d", d, p),
                32'({rsp_valid[d][p], rsp_result[d][p], rsp_err[d][p], rsp_zero[d][p]}), 0);
        end
        chk($sformatf("rst_busy_d%0d", d), 32'(busy[d]), 0);
        chk($sformatf("rst_count_d%0d", d), (d == 0) ? 32'(dc0) : 32'(dc1), 0);
        #1;
        rst[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                req_valid[d][p] = 1'b0;
                req_a[d][p] = '0;
                req_b[d][p] = '0;
                req_s[d][p] = '0;
                rsp_ready[d][p] = 1'b0;
            end
        end
        @(negedge clk);
        do_reset(0);
        do_reset(1);
        @(negedge clk);

        // Lone ADD 2,5: ready in the accept cycle, response two cycles later.
        rsp_ready[0][0] = 1'b1;
        rsp_ready[0][1] = 1'b1;
        push_op(0, 0, 8'd2, 8'd5, 4'd1);
        #1;
        chk("t2_accept_ready", 32'(req_ready[0][0]), 1);
        step();
        chk("t2_exec_busy", 32'(busy[0]), 1);
        chk("t2_exec_novalid", 32'(rsp_valid[0][0]), 0);
        step();
        chk("t2_resp_valid", 32'(rsp_valid[0][0]), 1);
        chk("t2_resp_result", 32'(rsp_result[0][0]), 7);
        step();
        chk("t2_done_count", 32'(dc0), 1);
        chk("t2_idle", 32'(busy[0]), 0);

        // Fair contention after reset: port 0 first, then alternation.
        do_reset(0);
        @(negedge clk);
        push_op(0, 0, 8'd5, 8'd2, 4'd2);
        push_op(0, 1, 8'hF0, 8'hFF, 4'd5);
        push_op(0, 0, 8'd1, 8'd1, 4'd1);
        push_op(0, 1, 8'd3, 8'd1, 4'd2);
        wait_idle(0, 40);
        chk("t3_grants", glog[0].size(), 4);
        if (glog[0].size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), glog[0][i], i % 2);
        chk("t3_done_count", 32'(dc0), 4);

        // Fixed priority: port 0 always wins while valid; 5 ops wrap a 2-bit count to 1.
        rsp_ready[1][0] = 1'b1;
        rsp_ready[1][1] = 1'b1;
        push_op(1, 0, 8'hFF, 8'd2, 4'd1);
        push_op(1, 1, 8'd2, 8'd5, 4'd2);
        push_op(1, 0, 8'h0F, 8'h3C, 4'd3);
        push_op(1, 1, 8'h0F, 8'h30, 4'd4);
        push_op(1, 0, 8'h55, 8'h00, 4'd6);
        wait_idle(1, 60);
        chk("t4_grants", glog[1].size(), 5);
        if (glog[1].size() >= 5)
            for (int i = 0; i < 5; i++)
                chk($sformatf("t4_grant%0d", i), glog[1][i], (i < 3) ? 0 : 1);
        chk("t4_done_wrap", 32'(dc1), 1);

        // Illegal opcode, shifts, and zero-result cases.
        push_op(0, 1, 8'd5, 8'd3, 4'd12);
        push_op(0, 0, 8'h81, 8'h00, 4'd7);
        push_op(0, 0, 8'h81, 8'h00, 4'd8);
        push_op(0, 0, 8'h00, 8'h00, 4'd0);
        push_op(0, 1, 8'h33, 8'h33, 4'd5);
        wait_idle(0, 60);

        // Response backpressure holds RESP and blocks the waiting requester.
        rsp_ready[0][0] = 1'b0;
        push_op(0, 0, 8'd10, 8'd20, 4'd1);
        step();
        push_op(0, 1, 8'd7, 8'd7, 4'd3);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t6_busy%0d", i), 32'(busy[0]), 1);
            chk($sformatf("t6_valid%0d", i), 32'(rsp_valid[0][0]), 1);
            chk($sformatf("t6_result%0d", i), 32'(rsp_result[0][0]), 30);
            chk($sformatf("t6_req1_blocked%0d", i), 32'(req_ready[0][1]), 0);
            step();
        end
        rsp_ready[0][0] = 1'b1;
        step();
        #1;
        chk("t6_req1_accept", 32'(req_ready[0][1]), 1);
        wait_idle(0, 20);

        // Reset during EXEC drops the operation.
        push_op(0, 0, 8'd1, 8'd2, 4'd1);
        step();
        chk("t7_in_exec", 32'(busy[0]), 1);
        do_reset(0);
        for (int i = 0; i < 4; i++) step();
        chk("t7_no_rsp0", 32'(rsp_valid[0][0]), 0);
        chk("t7_no_rsp1", 32'(rsp_valid[0][1]), 0);
        chk("t7_count", 32'(dc0), 0);

        for (int k = 0; k < 4; k++) chk($sformatf("sb_empty%0d", k), sb[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
